// File: rtl/regf_port_arbiter.sv
// Register-file port arbiter: three requesters share one register-file port.
// Selection is round-robin with optional per-owner burst lock, and only one access is in flight at a time.
module regf_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic [2:0]            i_req,
  input  logic [2:0]            i_lock,
  input  logic [2:0]            i_wr,
  input  logic [3*ADDR_W-1:0]   i_addr,
  input  logic [3*DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]     i_regf_data_rd,
  output logic                  o_regf_wr_en,
  output logic                  o_regf_rd_en,
  output logic [ADDR_W-1:0]     o_regf_addr,
  output logic [DATA_W-1:0]     o_regf_data_wr,
  output logic [2:0]            o_gnt,
  output logic [2:0]            o_ack,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_busy
);

  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [1:0]          rr_ptr_r, rr_ptr_s;
  logic [1:0]          owner_r, owner_s;
  logic [1:0]          wait_cnt_r, wait_cnt_s;
  logic                wr_r, wr_s;
  logic                locked_r, locked_s;
  logic [1:0]          sel_s;
  logic [2:0]          elig_s;
  logic                any_elig_s, unlock_s, owner_lock_s, sel_wr_s, last_wait_s;
  logic [ADDR_W-1:0]   sel_addr_s, addr_s;
  logic [DATA_W-1:0]   sel_wdata_s, wdata_s, rd_data_s;
  logic                wr_en_s, rd_en_s, busy_s;
  logic [2:0]          gnt_s, ack_s;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot3 = 3'b001;
      2'd1:    onehot3 = 3'b010;
      2'd2:    onehot3 = 3'b100;
      default: onehot3 = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    case (idx)
      2'd0:    next_idx = 2'd1;
      2'd1:    next_idx = 2'd2;
      default: next_idx = 2'd0;
    endcase
  endfunction

  // First eligible requester found scanning upward from the pointer, wrapping at 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] ptr);
    logic [1:0] c0, c1, c2;
    c0 = (ptr == 2'd3) ? 2'd0 : ptr;
    c1 = next_idx(c0);
    c2 = next_idx(c1);
    if ((elig & onehot3(c0)) != 3'b000) begin
      rr_pick = c0;
    end else if ((elig & onehot3(c1)) != 3'b000) begin
      rr_pick = c1;
    end else if ((elig & onehot3(c2)) != 3'b000) begin
      rr_pick = c2;
    end else begin
      rr_pick = 2'd0;
    end
  endfunction

  // Request qualification and selection of the winner's fields.
  always_comb begin
    owner_lock_s = |(i_lock & onehot3(owner_r));
    unlock_s     = (state_r == IDLE) && locked_r && !owner_lock_s;
    if (locked_r) begin
      elig_s = i_req & onehot3(owner_r);
    end else begin
      elig_s = i_req;
    end
    any_elig_s  = |elig_s;
    sel_s       = rr_pick(elig_s, rr_ptr_r);
    sel_wr_s    = |(i_wr & onehot3(sel_s));
    last_wait_s = (wait_cnt_r == LAST_WAIT);
    case (sel_s)
      2'd1: begin
        sel_addr_s  = i_addr[ADDR_W +: ADDR_W];
        sel_wdata_s = i_wdata[DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_addr_s  = i_addr[2*ADDR_W +: ADDR_W];
        sel_wdata_s = i_wdata[2*DATA_W +: DATA_W];
      end
      default: begin
        sel_addr_s  = i_addr[0 +: ADDR_W];
        sel_wdata_s = i_wdata[0 +: DATA_W];
      end
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!unlock_s && any_elig_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (wr_r) begin
          state_s = IDLE;
        end else begin
          state_s = RDWAIT;
        end
      end
      RDWAIT: begin
        if (last_wait_s) begin
          state_s = IDLE;
        end else begin
          state_s = RDWAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output and bookkeeping decode; results are registered so every output is a flop.
  always_comb begin
    rr_ptr_s   = rr_ptr_r;
    owner_s    = owner_r;
    wr_s       = wr_r;
    locked_s   = locked_r;
    wait_cnt_s = 2'd0;
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    addr_s     = o_regf_addr;
    wdata_s    = o_regf_data_wr;
    gnt_s      = o_gnt;
    ack_s      = 3'b000;
    rd_data_s  = o_rd_data;
    busy_s     = (state_s != IDLE);
    case (state_r)
      IDLE: begin
        if (unlock_s) begin
          // Lock released: spend this idle cycle reopening arbitration after the owner.
          locked_s = 1'b0;
          rr_ptr_s = next_idx(owner_r);
          gnt_s    = 3'b000;
        end else if (any_elig_s) begin
          owner_s = sel_s;
          wr_s    = sel_wr_s;
          addr_s  = sel_addr_s;
          wdata_s = sel_wdata_s;
          gnt_s   = onehot3(sel_s);
          wr_en_s = sel_wr_s;
          rd_en_s = !sel_wr_s;
          ack_s   = sel_wr_s ? onehot3(sel_s) : 3'b000;
        end else begin
          gnt_s = locked_r ? onehot3(owner_r) : 3'b000;
        end
      end
      ISSUE: begin
        if (wr_r) begin
          locked_s = owner_lock_s;
          rr_ptr_s = owner_lock_s ? rr_ptr_r : next_idx(owner_r);
          gnt_s    = owner_lock_s ? onehot3(owner_r) : 3'b000;
        end else begin
          wait_cnt_s = 2'd0;
        end
      end
      RDWAIT: begin
        if (last_wait_s) begin
          rd_data_s = i_regf_data_rd;
          ack_s     = onehot3(owner_r);
          locked_s  = owner_lock_s;
          rr_ptr_s  = owner_lock_s ? rr_ptr_r : next_idx(owner_r);
          gnt_s     = owner_lock_s ? onehot3(owner_r) : 3'b000;
        end else begin
          wait_cnt_s = wait_cnt_r + 2'd1;
        end
      end
      default: begin
        gnt_s = 3'b000;
      end
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state_r        <= IDLE;
      rr_ptr_r       <= 2'd0;
      owner_r        <= 2'd0;
      wait_cnt_r     <= 2'd0;
      wr_r           <= 1'b0;
      locked_r       <= 1'b0;
      o_regf_wr_en   <= 1'b0;
      o_regf_rd_en   <= 1'b0;
      o_regf_addr    <= '0;
      o_regf_data_wr <= '0;
      o_gnt          <= 3'b000;
      o_ack          <= 3'b000;
      o_rd_data      <= '0;
      o_busy         <= 1'b0;
    end else begin
      state_r        <= state_s;
      rr_ptr_r       <= rr_ptr_s;
      owner_r        <= owner_s;
      wait_cnt_r     <= wait_cnt_s;
      wr_r           <= wr_s;
      locked_r       <= locked_s;
      o_regf_wr_en   <= wr_en_s;
      o_regf_rd_en   <= rd_en_s;
      o_regf_addr    <= addr_s;
      o_regf_data_wr <= wdata_s;
      o_gnt          <= gnt_s;
      o_ack          <= ack_s;
      o_rd_data      <= rd_data_s;
      o_busy         <= busy_s;
    end
  end

endmodule
